// File: rtl/addsub_pipe_if.sv
// Valid/ready operand and result bundle for addsub_pipe.
// The slave side is the arithmetic block; the master side is the upstream/downstream environment.
interface addsub_pipe_if #(
  parameter int P_DATA_SIZE = 16
);
  logic                   i_vld;
  logic                   o_rdy;
  logic [P_DATA_SIZE-1:0] i_a;
  logic [P_DATA_SIZE-1:0] i_b;
  logic                   i_c;
  logic                   i_sub;
  logic                   o_vld;
  logic                   i_rdy;
  logic [P_DATA_SIZE:0]   o_s;

  modport slave (
    input  i_vld, i_a, i_b, i_c, i_sub, i_rdy,
    output o_rdy, o_vld, o_s
  );

  modport master (
    output i_vld, i_a, i_b, i_c, i_sub, i_rdy,
    input  o_rdy, o_vld, o_s
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add-with-carry / subtract-with-borrow with a segmented carry chain and
// valid/ready flow control whose bubbles collapse under backpressure.
module addsub_pipe #(
  parameter int P_DATA_SIZE = 16,
  parameter int P_NUM_PIPE  = 2,
  parameter int P_IN_REG    = 0,
  parameter int P_OUT_REG   = 0,
  parameter int P_SIGNED    = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  addsub_pipe_if.slave io
);
  localparam int N = P_DATA_SIZE;
  localparam int M = N + 1;
  localparam int L = P_IN_REG + P_NUM_PIPE + P_OUT_REG;
  localparam int W = (N + P_NUM_PIPE) / (P_NUM_PIPE + 1);
  localparam logic [M:0] ONE = {{M{1'b0}}, 1'b1};

  // One in-flight transaction: extended operands (B already conditioned for sub),
  // the low result bits finished so far, and the carry into the next segment.
  typedef struct packed {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] s;
    logic         cy;
  } pay_t;

  // Segment k covers bits [lo, hi); the last one runs to the extension bit. With a
  // coarse W, middle segments may be empty and the carry then lands directly at hi.
  function automatic pay_t seg_add(input pay_t p, input int k);
    pay_t       r;
    int         lo;
    int         hi;
    logic [M:0] mask;
    logic [M:0] sum;
    lo   = (k * W < M) ? k * W : M;
    hi   = (k == P_NUM_PIPE || (k + 1) * W >= M) ? M : (k + 1) * W;
    mask = ((ONE << hi) - ONE) ^ ((ONE << lo) - ONE);
    sum  = ({1'b0, p.a} & mask) + ({1'b0, p.b} & mask) + ({{M{1'b0}}, p.cy} << lo);
    r    = p;
    r.s  = p.s | (sum[M-1:0] & mask[M-1:0]);
    r.cy = |(sum & (ONE << hi));
    return r;
  endfunction

  function automatic logic [M-1:0] seg_s(input pay_t p, input int k);
    pay_t r;
    r = seg_add(p, k);
    return r.s;
  endfunction

  pay_t         prep;
  pay_t         pipe [0:L];
  logic [M-1:0] a_ext;
  logic [M-1:0] b_ext;

  // Subtraction is A + ~B + (1 - C), so the borrow-in becomes an inverted carry-in.
  always_comb begin
    a_ext     = (P_SIGNED != 0) ? {io.i_a[N-1], io.i_a} : {1'b0, io.i_a};
    b_ext     = (P_SIGNED != 0) ? {io.i_b[N-1], io.i_b} : {1'b0, io.i_b};
    prep.a    = a_ext;
    prep.b    = io.i_sub ? ~b_ext : b_ext;
    prep.s    = '0;
    prep.cy   = io.i_c ^ io.i_sub;
  end

  assign pipe[0]  = prep;
  assign io.o_s   = (P_OUT_REG != 0) ? pipe[L].s : seg_s(pipe[L], P_NUM_PIPE);

  if (L == 0) begin : g_comb
    assign io.o_vld = io.i_vld;
    assign io.o_rdy = io.i_rdy;
  end else begin : g_pipe
    logic [L-1:0] vld;
    logic [L-1:0] en;
    logic         nxt;

    // NOTE: every variable written here gets a value before any branch or loop can
    // skip it; otherwise the tool infers a latch to hold the old value.
    always_comb begin
      en  = '0;
      nxt = io.i_rdy;
      for (int j = L - 1; j >= 0; j--) begin
        en[j] = !vld[j] || nxt;
        nxt   = en[j];
      end
    end

    for (genvar j = 0; j < L; j++) begin : g_stage
      logic vld_d;
      logic vld_q;
      pay_t dat_d;
      pay_t dat_q;

      if (j == 0) begin : g_head
        assign vld_d = io.i_vld;
      end else begin : g_body
        assign vld_d = vld[j-1];
      end

      if (j < P_IN_REG) begin : g_in
        assign dat_d = pipe[j];
      end else begin : g_seg
        assign dat_d = seg_add(pipe[j], j - P_IN_REG);
      end

      // NOTE: sequential state uses non-blocking assignments so every stage samples
      // its predecessor's pre-edge value. Data registers are reset too, so o_s reads
      // zero while i_rst_n is low rather than stale in-flight data.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (en[j]) begin
          vld_q <= vld_d;
          if (vld_d) dat_q <= dat_d;
        end
      end

      assign vld[j]      = vld_q;
      assign pipe[j + 1] = dat_q;
    end

    assign io.o_vld = vld[L-1];
    assign io.o_rdy = en[0];
  end
endmodule
